// File: rtl/char_writer.sv
// Byte-queued UART transmitter: FIFO of bytes drained onto an 8N1 serial line, LSB first.
// Latency: byte written at edge N into an idle, empty writer drives the start bit after edge N+2.
// Backpressure: ready drops when the FIFO is full; writes while full are dropped and latch overflow.
module char_writer #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char,
  input  logic       newChar,
  output logic       ready,
  output logic       UART_TX,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;

  logic fifo_full;
  logic fifo_empty;
  logic baud_end;
  logic wr_en;
  logic pop;

  // Full check uses the registered count, so a same-edge pop never makes room for a write.
  always_comb begin
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);
    baud_end   = (baud_cnt == BAUD_LAST);
    wr_en      = newChar && !fifo_full;
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
  end

  assign ready = !fifo_full;
  assign busy  = (state != IDLE) || !fifo_empty;

  // Byte storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= char;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (newChar && fifo_full) overflow <= 1'b1;
    end
  end

  // Frame sequencer; UART_TX is registered from the current state so it trails state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      UART_TX   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          UART_TX  <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            bit_cnt   <= '0;
            state     <= START;
          end
        end
        START: begin
          UART_TX <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          UART_TX <= shift_reg[0];
          if (baud_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          UART_TX <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              // Next byte starts immediately: no idle gap between frames.
              shift_reg <= mem[rd_ptr];
              bit_cnt   <= '0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          UART_TX <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/char_writer.md
CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (9600 baud at clk = 1 MHz); legal range 4..1023.
REQ-002 Parameter FIFO_DEPTH, default 8, number of byte entries in the transmit FIFO; power of two, 2..64.
REQ-003 clk  input  1  single clock (clk_1MHz domain); all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 char  input  8  byte to transmit, sampled when newChar = 1.
REQ-006 newChar  input  1  one-cycle write strobe; one strobe = one byte queued.
REQ-007 ready  output  1  high when FIFO not full (write will be accepted this cycle).
REQ-008 UART_TX  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a frame is on the line or FIFO non-empty.
REQ-010 overflow  output  1  sticky flag: a write was dropped because FIFO was full.

Function
REQ-011 FIFO: write when newChar = 1 and FIFO not full (count < FIFO_DEPTH before the edge); pointers wrap modulo FIFO_DEPTH.
REQ-012 newChar = 1 with FIFO full: byte dropped, FIFO contents unchanged, overflow set to 1 on that edge, held until rst.
REQ-013 Full check uses pre-edge count; a pop on the same edge does not make room for a simultaneous write to a full FIFO.
REQ-014 Simultaneous write and pop on non-full FIFO: both performed, count unchanged.
REQ-015 count width clog2(FIFO_DEPTH)+1 bits; ready = (count != FIFO_DEPTH) combinationally from registered count.
REQ-016 FSM states IDLE, START, DATA, STOP; registered UART_TX, no combinational path from inputs to UART_TX.
REQ-017 IDLE: UART_TX = 1; if FIFO non-empty, pop head into shift register, clear bit counter, go START.
REQ-018 START: UART_TX = 0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: UART_TX = shift[0], each bit held CLKS_PER_BIT cycles, shift right after each bit; after bit 7 go STOP.
REQ-020 STOP: UART_TX = 1 for CLKS_PER_BIT cycles; then pop next byte if FIFO non-empty and go START directly (back-to-back frames, no extra idle), else IDLE.
REQ-021 Frame length exactly 10*CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1 and wraps, width clog2(CLKS_PER_BIT).
REQ-022 Latency: byte written at edge N into empty FIFO with FSM in IDLE -> popped at edge N+1 -> UART_TX low after edge N+2.
REQ-023 busy = (state != IDLE) or (count != 0).
REQ-024 Bytes transmitted in write order; no byte duplicated or skipped except those dropped per REQ-012.
REQ-025 char changes while newChar = 0 have no effect.

Reset
REQ-026 rst = 1 at an edge: state IDLE, UART_TX = 1, FIFO pointers and count 0, baud and bit counters 0, overflow 0, ready 1, busy 0.
REQ-027 rst mid-frame aborts the frame: UART_TX high after that edge; queued bytes discarded; a newChar coincident with rst is ignored.
REQ-028 After rst deasserts, the first write behaves per REQ-022.

Verification
REQ-029 Single byte: CLKS_PER_BIT=4, write 0xA5 -> after 2 edges UART_TX bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each; busy low after 42 cycles total.
REQ-030 Back-to-back: write 0x00 then 0xFF on consecutive cycles -> frames contiguous, stop bit of first immediately followed by start bit of second, 80 cycles of frames at CLKS_PER_BIT=4.
REQ-031 Overflow: FIFO_DEPTH=8, 10 consecutive writes 0x01..0x0A during a frame -> ready low after FIFO fills, overflow=1, line carries 0x01..0x09 (one in shifter plus 8 queued), 0x0A dropped.
REQ-032 Full plus pop same edge: FIFO full, write 0x55 on the edge STOP pops -> 0x55 dropped, overflow=1, count becomes FIFO_DEPTH-1.
REQ-033 Reset mid-frame: assert rst during DATA bit 3 of 0x3C with 2 bytes queued -> UART_TX=1, busy=0, ready=1, overflow=0 next cycle; no further frames emitted.
REQ-034 Pointer wrap: 20 writes paced to keep 1..3 entries queued (FIFO_DEPTH=8) -> all 20 bytes emitted in order, overflow stays 0.
